alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_shifter.sv | 22 ++
 rtl/alu.sv | 101 ++++++++++
 tb/tb_alu.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, default width and the parity helper.
// PF generation in the top level is enabled by the ALU_PARITY_EN macro.
package alu_pkg;

    localparam logic OP_NOT = 1'b0;
    localparam logic OP_SHL = 1'b1;

    localparam int unsigned ALU_WIDTH_DEF = 5;

    // Even-parity flag: 1 when the value holds an even number of ones (zero extension is harmless).
    function automatic logic even_parity(input logic [31:0] value);
        return ~(^value);
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational logical left barrel shifter with carry-out of the last bit shifted out.
// Shifting the value one bit wider than A leaves the carry in the extra MSB for every B.
module alu_shifter #(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] res_o,
    output logic             cout_o
);

    logic [WIDTH:0] ext_s;

    // Extended shift: bit WIDTH holds A[WIDTH-B] for 1<=B<=WIDTH and zero otherwise.
    always_comb begin
        ext_s = {1'b0, a_i} << b_i;
    end

    assign res_o  = ext_s[WIDTH-1:0];
    assign cout_o = ext_s[WIDTH];

endmodule

// File: rtl/alu.sv
// Registered two-operation ALU (bitwise NOT, logical shift left) with CF/SF/ZF flags.
// Defining ALU_PARITY_EN adds a registered even-parity output PF.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             OP,
    output logic [WIDTH-1:0] R,
    output logic             CF,
    output logic             SF,
    output logic             ZF
`ifdef ALU_PARITY_EN
    ,
    output logic             PF
`endif
);

    logic [WIDTH-1:0] shl_res_s;
    logic             shl_cout_s;
    logic [WIDTH-1:0] r_d, r_q;
    logic             cf_d, cf_q;
    logic             sf_d, sf_q;
    logic             zf_d, zf_q;

    alu_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .a_i    (A),
        .b_i    (B),
        .res_o  (shl_res_s),
        .cout_o (shl_cout_s)
    );

    // Operation mux; flags are derived from this same next result so they never mix cycles.
    always_comb begin
        r_d  = {WIDTH{1'b0}};
        cf_d = 1'b0;
        case (OP)
            OP_NOT: begin
                r_d  = ~A;
                cf_d = 1'b0;
            end
            OP_SHL: begin
                r_d  = shl_res_s;
                cf_d = shl_cout_s;
            end
            default: begin
                r_d  = {WIDTH{1'b0}};
                cf_d = 1'b0;
            end
        endcase
        sf_d = r_d[WIDTH-1];
        zf_d = (r_d == {WIDTH{1'b0}});
    end

    // Output registers; reset presents a consistent all-zero result (ZF set).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q  <= {WIDTH{1'b0}};
            cf_q <= 1'b0;
            sf_q <= 1'b0;
            zf_q <= 1'b1;
        end else begin
            r_q  <= r_d;
            cf_q <= cf_d;
            sf_q <= sf_d;
            zf_q <= zf_d;
        end
    end

    assign R  = r_q;
    assign CF = cf_q;
    assign SF = sf_q;
    assign ZF = zf_q;

`ifdef ALU_PARITY_EN
    logic pf_d, pf_q;

    // Parity of the next result, zero extended to the helper's fixed width.
    always_comb begin
        pf_d = even_parity(32'(r_d));
    end

    // PF is forced low in reset to match the other reset flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pf_q <= 1'b0;
        end else begin
            pf_q <= pf_d;
        end
    end

    assign PF = pf_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed scenarios plus randomized back-to-back traffic
// compared against an arithmetic reference model of the operations.
module tb_alu;

    localparam int W    = 5;
    localparam int MASK = (1 << W) - 1;

    logic         clk;
    logic         rst;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         OP;
    logic [W-1:0] R;
    logic         CF;
    logic         SF;
    logic         ZF;
`ifdef ALU_PARITY_EN
    logic         PF;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    alu #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .OP  (OP),
        .R   (R),
        .CF  (CF),
        .SF  (SF),
        .ZF  (ZF)
`ifdef ALU_PARITY_EN
        ,
        .PF  (PF)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: returns {CF, R} from plain integer arithmetic on the operation rules.
    function automatic logic [W:0] model(input int a, input int b, input bit op);
        int r;
        int cf;
        if (op == 1'b0) begin
            r = (~a) & MASK;
            cf = 0;
        end else if (b == 0) begin
            r = a;
            cf = 0;
        end else if (b < W) begin
            r = (a * (1 << b)) & MASK;
            cf = (a / (1 << (W - b))) % 2;
        end else if (b == W) begin
            r = 0;
            cf = a % 2;
        end else begin
            r = 0;
            cf = 0;
        end
        return {cf[0], r[W-1:0]};
    endfunction

    task automatic drive_cycle(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        @(negedge clk);
        A  = a;
        B  = b;
        OP = op;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        A = 5'b10101; B = 5'd0; OP = 1'b0;
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({R, CF, SF, ZF} !== {5'b00000, 1'b0, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_async: got R=%b CF=%b SF=%b ZF=%b want R=00000 CF=0 SF=0 ZF=1", R, CF, SF, ZF);
        end
`ifdef ALU_PARITY_EN
        tests_run++;
        if (PF !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_pf: got PF=%b want 0", PF);
        end
`endif
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({R, CF, SF, ZF} !== {5'b00000, 1'b0, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_hold: got R=%b CF=%b SF=%b ZF=%b want R=00000 CF=0 SF=0 ZF=1", R, CF, SF, ZF);
        end
        @(negedge clk);
        rst = 1'b0;
        drive_cycle(5'b00000, 5'd0, 1'b0);
        tests_run++;
        if ({R, CF, SF, ZF} !== {5'b11111, 1'b0, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_first_result: got R=%b CF=%b SF=%b ZF=%b want R=11111 CF=0 SF=1 ZF=0", R, CF, SF, ZF);
        end
    endtask

    task automatic test_not();
        logic [W-1:0] a_tab [2] = '{5'b10101, 5'b11111};
        logic [7:0]   exp_tab [2] = '{{5'b01010, 1'b0, 1'b0, 1'b0}, {5'b00000, 1'b0, 1'b0, 1'b1}};
        for (int i = 0; i < 2; i++) begin
            drive_cycle(a_tab[i], 5'd7, 1'b0);
            tests_run++;
            if ({R, CF, SF, ZF} !== exp_tab[i]) begin
                tests_failed++;
                $display("FAIL not_%0d: got {R,CF,SF,ZF}=%b want %b", i, {R, CF, SF, ZF}, exp_tab[i]);
            end
        end
    endtask

    task automatic test_shift();
        logic [W-1:0] a_tab [4] = '{5'b11101, 5'b11101, 5'b11101, 5'b10101};
        logic [W-1:0] b_tab [4] = '{5'd0, 5'd1, 5'd3, 5'd2};
        logic [7:0]   exp_tab [4] = '{{5'b11101, 1'b0, 1'b1, 1'b0},
                                      {5'b11010, 1'b1, 1'b1, 1'b0},
                                      {5'b01000, 1'b1, 1'b0, 1'b0},
                                      {5'b10100, 1'b0, 1'b1, 1'b0}};
        for (int i = 0; i < 4; i++) begin
            drive_cycle(a_tab[i], b_tab[i], 1'b1);
            tests_run++;
            if ({R, CF, SF, ZF} !== exp_tab[i]) begin
                tests_failed++;
                $display("FAIL shift_%0d: got {R,CF,SF,ZF}=%b want %b", i, {R, CF, SF, ZF}, exp_tab[i]);
            end
        end
    endtask

    task automatic test_boundary();
        logic [W-1:0] b_tab [3] = '{5'd4, 5'd5, 5'd31};
        logic [7:0]   exp_tab [3] = '{{5'b00000, 1'b1, 1'b0, 1'b1},
                                      {5'b00000, 1'b0, 1'b0, 1'b1},
                                      {5'b00000, 1'b0, 1'b0, 1'b1}};
        for (int i = 0; i < 3; i++) begin
            drive_cycle(5'b01010, b_tab[i], 1'b1);
            tests_run++;
            if ({R, CF, SF, ZF} !== exp_tab[i]) begin
                tests_failed++;
                $display("FAIL boundary_b%0d: got {R,CF,SF,ZF}=%b want %b", b_tab[i], {R, CF, SF, ZF}, exp_tab[i]);
            end
        end
        drive_cycle(5'b10001, 5'd5, 1'b1);
        tests_run++;
        if ({R, CF, ZF} !== {5'b00000, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("FAIL boundary_b5_cf: got R=%b CF=%b ZF=%b want R=00000 CF=1 ZF=1", R, CF, ZF);
        end
    endtask

    task automatic test_midstream_reset();
        drive_cycle(5'b00111, 5'd1, 1'b1);
        tests_run++;
        if ({R, CF, SF, ZF} !== {5'b01110, 1'b0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL mid_first: got {R,CF,SF,ZF}=%b want 01110000", {R, CF, SF, ZF});
        end
        A = 5'b10011; B = 5'd2; OP = 1'b1;
        #1 rst = 1'b1;
        #1;
        tests_run++;
        if ({R, CF, SF, ZF} !== {5'b00000, 1'b0, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL mid_snap: got {R,CF,SF,ZF}=%b want 00000001", {R, CF, SF, ZF});
        end
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if ({R, CF, SF, ZF} !== {5'b01100, 1'b0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL mid_after: got {R,CF,SF,ZF}=%b want 01100000", {R, CF, SF, ZF});
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         op;
        logic [W:0]   exp;
        for (int i = 0; i < 300; i++) begin
            a  = W'($urandom);
            b  = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 7)) : W'($urandom);
            op = 1'($urandom);
            exp = model(int'(a), int'(b), op);
            drive_cycle(a, b, op);
            tests_run++;
            if ({R, CF, SF, ZF} !== {exp[W-1:0], exp[W], exp[W-1], (exp[W-1:0] == 5'd0)}) begin
                tests_failed++;
                $display("FAIL random_%0d: A=%b B=%0d OP=%b got R=%b CF=%b SF=%b ZF=%b want R=%b CF=%b",
                         i, a, b, op, R, CF, SF, ZF, exp[W-1:0], exp[W]);
            end
`ifdef ALU_PARITY_EN
            tests_run++;
            if (PF !== (($countones(exp[W-1:0]) % 2) == 0)) begin
                tests_failed++;
                $display("FAIL random_pf_%0d: got PF=%b for R=%b", i, PF, exp[W-1:0]);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_not();
        test_shift();
        test_boundary();
        test_midstream_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
